// File: rtl/clock_pkg.sv
// Shared codes for the clock setting flow: modes, edit positions, digit limits.
// display_control decodes mode/pos with these same values.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'b00,
        MODE_CLOCK_SET = 2'b01,
        MODE_ALARM_SET = 2'b10
    } mode_e;

    localparam logic [2:0] POS_NONE   = 3'd0;
    localparam logic [2:0] POS_HOUR_T = 3'd1;
    localparam logic [2:0] POS_HOUR_O = 3'd2;
    localparam logic [2:0] POS_MIN_T  = 3'd3;
    localparam logic [2:0] POS_MIN_O  = 3'd4;
    localparam logic [2:0] POS_SEC_T  = 3'd5;
    localparam logic [2:0] POS_SEC_O  = 3'd6;

    localparam logic [1:0] HOUR_T_MAX       = 2'd2;
    localparam logic [3:0] HOUR_O_MAX       = 4'd9;
    localparam logic [3:0] HOUR_O_MAX_AT_20 = 4'd3;
    localparam logic [2:0] MS_T_MAX         = 3'd5;
    localparam logic [3:0] MS_O_MAX         = 4'd9;

    // Advance an edit position, wrapping from the last editable digit back to hour tens.
    function automatic logic [2:0] next_pos(input logic [2:0] pos, input logic [2:0] last);
        if (pos == POS_NONE || pos >= last) begin
            return POS_HOUR_T;
        end
        return pos + 3'd1;
    endfunction

endpackage

// File: rtl/set_digit_incr.sv
// Combinational single-digit incrementer for the time/alarm editor.
// Only the digit selected by pos_i changes (plus the hour-ones clamp when the
// hour tens reaches 2). Wraps never carry into a neighbouring digit.
// wide_i=1 allows all six positions; wide_i=0 (alarm) limits editing to pos 1..4.
module set_digit_incr
    import clock_pkg::*;
(
    input  logic [2:0] pos_i,
    input  logic       wide_i,
    input  logic [1:0] hour_tens_i,
    input  logic [3:0] hour_ones_i,
    input  logic [2:0] min_tens_i,
    input  logic [3:0] min_ones_i,
    input  logic [2:0] sec_tens_i,
    input  logic [3:0] sec_ones_i,
    output logic [1:0] hour_tens_o,
    output logic [3:0] hour_ones_o,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [2:0] sec_tens_o,
    output logic [3:0] sec_ones_o
);

    logic [3:0] hour_o_limit;

    // Next value of the selected digit; all others pass through unchanged.
    always_comb begin
        hour_tens_o  = hour_tens_i;
        hour_ones_o  = hour_ones_i;
        min_tens_o   = min_tens_i;
        min_ones_o   = min_ones_i;
        sec_tens_o   = sec_tens_i;
        sec_ones_o   = sec_ones_i;
        hour_o_limit = (hour_tens_i == HOUR_T_MAX) ? HOUR_O_MAX_AT_20 : HOUR_O_MAX;

        case (pos_i)
            POS_HOUR_T: begin
                if (hour_tens_i >= HOUR_T_MAX) begin
                    hour_tens_o = 2'd0;
                end else begin
                    hour_tens_o = hour_tens_i + 2'd1;
                end
                // Entering the 20s must not leave an invalid hour such as 29.
                if (hour_tens_o == HOUR_T_MAX && hour_ones_i > HOUR_O_MAX_AT_20) begin
                    hour_ones_o = HOUR_O_MAX_AT_20;
                end
            end
            POS_HOUR_O: begin
                if (hour_ones_i >= hour_o_limit) begin
                    hour_ones_o = 4'd0;
                end else begin
                    hour_ones_o = hour_ones_i + 4'd1;
                end
            end
            POS_MIN_T: begin
                if (min_tens_i >= MS_T_MAX) begin
                    min_tens_o = 3'd0;
                end else begin
                    min_tens_o = min_tens_i + 3'd1;
                end
            end
            POS_MIN_O: begin
                if (min_ones_i >= MS_O_MAX) begin
                    min_ones_o = 4'd0;
                end else begin
                    min_ones_o = min_ones_i + 4'd1;
                end
            end
            POS_SEC_T: begin
                if (wide_i) begin
                    if (sec_tens_i >= MS_T_MAX) begin
                        sec_tens_o = 3'd0;
                    end else begin
                        sec_tens_o = sec_tens_i + 3'd1;
                    end
                end
            end
            POS_SEC_O: begin
                if (wide_i) begin
                    if (sec_ones_i >= MS_O_MAX) begin
                        sec_ones_o = 4'd0;
                    end else begin
                        sec_ones_o = sec_ones_i + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/time_set_controller.sv
// User-setting sequencer for the clock: NORMAL -> CLOCK_SET -> ALARM_SET -> NORMAL
// on btn_mode, with btn_next moving the edit position and btn_inc bumping the
// selected digit. Owns the shadow edit time and the alarm registers, pulses
// time_load when leaving CLOCK_SET, and abandons a set mode after TIMEOUT_S idle
// seconds. The mode output is the FSM state itself, so it doubles as the state view.
// Same-cycle priority: btn_mode > btn_next > btn_inc > timeout tick.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic [1:0] cur_hour_tens,
    input  logic [3:0] cur_hour_ones,
    input  logic [2:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [2:0] cur_sec_tens,
    input  logic [3:0] cur_sec_ones,
    output logic [1:0] mode,
    output logic [2:0] pos,
    output logic [1:0] edit_hour_tens,
    output logic [3:0] edit_hour_ones,
    output logic [2:0] edit_min_tens,
    output logic [3:0] edit_min_ones,
    output logic [2:0] edit_sec_tens,
    output logic [3:0] edit_sec_ones,
    output logic       time_load,
    output logic [1:0] alarm_hour_tens,
    output logic [3:0] alarm_hour_ones,
    output logic [2:0] alarm_min_tens,
    output logic [3:0] alarm_min_ones,
    output logic       alarm_en
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_S - 1);

    mode_e      mode_q;
    logic [2:0] pos_q;
    logic [7:0] to_cnt_q;
    logic       time_load_q;
    logic       alarm_en_q;

    logic [1:0] edit_ht_q;
    logic [3:0] edit_ho_q;
    logic [2:0] edit_mt_q;
    logic [3:0] edit_mo_q;
    logic [2:0] edit_st_q;
    logic [3:0] edit_so_q;

    logic [1:0] alarm_ht_q;
    logic [3:0] alarm_ho_q;
    logic [2:0] alarm_mt_q;
    logic [3:0] alarm_mo_q;

    logic       in_alarm;
    logic [1:0] src_ht;
    logic [3:0] src_ho;
    logic [2:0] src_mt;
    logic [3:0] src_mo;

    logic [1:0] inc_ht_d;
    logic [3:0] inc_ho_d;
    logic [2:0] inc_mt_d;
    logic [3:0] inc_mo_d;
    logic [2:0] inc_st_d;
    logic [3:0] inc_so_d;

    assign in_alarm = (mode_q == MODE_ALARM_SET);

    // One shared incrementer: source is the alarm in ALARM_SET, the edit time otherwise.
    always_comb begin
        src_ht = edit_ht_q;
        src_ho = edit_ho_q;
        src_mt = edit_mt_q;
        src_mo = edit_mo_q;
        if (in_alarm) begin
            src_ht = alarm_ht_q;
            src_ho = alarm_ho_q;
            src_mt = alarm_mt_q;
            src_mo = alarm_mo_q;
        end
    end

    set_digit_incr u_incr (
        .pos_i       (pos_q),
        .wide_i      (~in_alarm),
        .hour_tens_i (src_ht),
        .hour_ones_i (src_ho),
        .min_tens_i  (src_mt),
        .min_ones_i  (src_mo),
        .sec_tens_i  (edit_st_q),
        .sec_ones_i  (edit_so_q),
        .hour_tens_o (inc_ht_d),
        .hour_ones_o (inc_ho_d),
        .min_tens_o  (inc_mt_d),
        .min_ones_o  (inc_mo_d),
        .sec_tens_o  (inc_st_d),
        .sec_ones_o  (inc_so_d)
    );

    // Mode FSM, edit position, timeout counter and the edit/alarm registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_NORMAL;
            pos_q       <= POS_NONE;
            to_cnt_q    <= 8'd0;
            time_load_q <= 1'b0;
            alarm_en_q  <= 1'b0;
            edit_ht_q   <= 2'd0;
            edit_ho_q   <= 4'd0;
            edit_mt_q   <= 3'd0;
            edit_mo_q   <= 4'd0;
            edit_st_q   <= 3'd0;
            edit_so_q   <= 4'd0;
            alarm_ht_q  <= 2'd0;
            alarm_ho_q  <= 4'd0;
            alarm_mt_q  <= 3'd0;
            alarm_mo_q  <= 4'd0;
        end else begin
            time_load_q <= 1'b0;
            if (btn_mode) begin
                to_cnt_q <= 8'd0;
                case (mode_q)
                    MODE_NORMAL: begin
                        mode_q    <= MODE_CLOCK_SET;
                        pos_q     <= POS_HOUR_T;
                        edit_ht_q <= cur_hour_tens;
                        edit_ho_q <= cur_hour_ones;
                        edit_mt_q <= cur_min_tens;
                        edit_mo_q <= cur_min_ones;
                        edit_st_q <= cur_sec_tens;
                        edit_so_q <= cur_sec_ones;
                    end
                    MODE_CLOCK_SET: begin
                        mode_q      <= MODE_ALARM_SET;
                        pos_q       <= POS_HOUR_T;
                        time_load_q <= 1'b1;
                    end
                    default: begin
                        mode_q <= MODE_NORMAL;
                        pos_q  <= POS_NONE;
                    end
                endcase
            end else if (btn_next) begin
                to_cnt_q <= 8'd0;
                case (mode_q)
                    MODE_CLOCK_SET: pos_q <= next_pos(pos_q, POS_SEC_O);
                    MODE_ALARM_SET: pos_q <= next_pos(pos_q, POS_MIN_O);
                    default: ;
                endcase
            end else if (btn_inc) begin
                to_cnt_q <= 8'd0;
                case (mode_q)
                    MODE_NORMAL: alarm_en_q <= ~alarm_en_q;
                    MODE_CLOCK_SET: begin
                        edit_ht_q <= inc_ht_d;
                        edit_ho_q <= inc_ho_d;
                        edit_mt_q <= inc_mt_d;
                        edit_mo_q <= inc_mo_d;
                        edit_st_q <= inc_st_d;
                        edit_so_q <= inc_so_d;
                    end
                    default: begin
                        alarm_ht_q <= inc_ht_d;
                        alarm_ho_q <= inc_ho_d;
                        alarm_mt_q <= inc_mt_d;
                        alarm_mo_q <= inc_mo_d;
                    end
                endcase
            end else if (tick_1hz && mode_q != MODE_NORMAL) begin
                // Idle expiry discards clock edits (no load); alarm writes already stuck.
                if (to_cnt_q >= TO_LAST) begin
                    mode_q   <= MODE_NORMAL;
                    pos_q    <= POS_NONE;
                    to_cnt_q <= 8'd0;
                end else begin
                    to_cnt_q <= to_cnt_q + 8'd1;
                end
            end
        end
    end

    assign mode            = mode_q;
    assign pos             = pos_q;
    assign time_load       = time_load_q;
    assign alarm_en        = alarm_en_q;
    assign edit_hour_tens  = edit_ht_q;
    assign edit_hour_ones  = edit_ho_q;
    assign edit_min_tens   = edit_mt_q;
    assign edit_min_ones   = edit_mo_q;
    assign edit_sec_tens   = edit_st_q;
    assign edit_sec_ones   = edit_so_q;
    assign alarm_hour_tens = alarm_ht_q;
    assign alarm_hour_ones = alarm_ho_q;
    assign alarm_min_tens  = alarm_mt_q;
    assign alarm_min_ones  = alarm_mo_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with TIMEOUT_S=3.
module tb_time_set_controller;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic [1:0] cur_hour_tens;
    logic [3:0] cur_hour_ones;
    logic [2:0] cur_min_tens;
    logic [3:0] cur_min_ones;
    logic [2:0] cur_sec_tens;
    logic [3:0] cur_sec_ones;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [1:0] edit_hour_tens;
    logic [3:0] edit_hour_ones;
    logic [2:0] edit_min_tens;
    logic [3:0] edit_min_ones;
    logic [2:0] edit_sec_tens;
    logic [3:0] edit_sec_ones;
    logic       time_load;
    logic [1:0] alarm_hour_tens;
    logic [3:0] alarm_hour_ones;
    logic [2:0] alarm_min_tens;
    logic [3:0] alarm_min_ones;
    logic       alarm_en;

    int checks = 0;
    int errors = 0;
    int tl_count = 0;
    int tl_base;

    time_set_controller #(.TIMEOUT_S(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_1hz        (tick_1hz),
        .btn_mode        (btn_mode),
        .btn_next        (btn_next),
        .btn_inc         (btn_inc),
        .cur_hour_tens   (cur_hour_tens),
        .cur_hour_ones   (cur_hour_ones),
        .cur_min_tens    (cur_min_tens),
        .cur_min_ones    (cur_min_ones),
        .cur_sec_tens    (cur_sec_tens),
        .cur_sec_ones    (cur_sec_ones),
        .mode            (mode),
        .pos             (pos),
        .edit_hour_tens  (edit_hour_tens),
        .edit_hour_ones  (edit_hour_ones),
        .edit_min_tens   (edit_min_tens),
        .edit_min_ones   (edit_min_ones),
        .edit_sec_tens   (edit_sec_tens),
        .edit_sec_ones   (edit_sec_ones),
        .time_load       (time_load),
        .alarm_hour_tens (alarm_hour_tens),
        .alarm_hour_ones (alarm_hour_ones),
        .alarm_min_tens  (alarm_min_tens),
        .alarm_min_ones  (alarm_min_ones),
        .alarm_en        (alarm_en)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count time_load high cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (time_load) tl_count++;
    end

    function automatic logic [19:0] mk_time(input int ht, ho, mt, mo, st, so);
        return {ht[1:0], ho[3:0], mt[2:0], mo[3:0], st[2:0], so[3:0]};
    endfunction

    function automatic logic [12:0] mk_alarm(input int ht, ho, mt, mo);
        return {ht[1:0], ho[3:0], mt[2:0], mo[3:0]};
    endfunction

    function automatic logic [19:0] edit_now();
        return {edit_hour_tens, edit_hour_ones, edit_min_tens, edit_min_ones,
                edit_sec_tens, edit_sec_ones};
    endfunction

    function automatic logic [12:0] alarm_now();
        return {alarm_hour_tens, alarm_hour_ones, alarm_min_tens, alarm_min_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cur(input int ht, ho, mt, mo, st, so);
        cur_hour_tens = 2'(ht);
        cur_hour_ones = 4'(ho);
        cur_min_tens  = 3'(mt);
        cur_min_ones  = 4'(mo);
        cur_sec_tens  = 3'(st);
        cur_sec_ones  = 4'(so);
    endtask

    // One-cycle pulse on any combination of inputs; returns at the next negedge.
    task automatic drive(input logic m, input logic n, input logic i, input logic t);
        @(negedge clk);
        btn_mode = m;
        btn_next = n;
        btn_inc  = i;
        tick_1hz = t;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic press_mode(); drive(1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic press_next(); drive(1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic press_inc();  drive(1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic tick();       drive(1'b0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        set_cur(1, 3, 4, 5, 2, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_edit", 32'(edit_now()), 32'd0);
        check("rst_alarm", 32'(alarm_now()), 32'd0);
        check("rst_alarm_en", 32'(alarm_en), 32'd0);
        check("rst_time_load", 32'(time_load), 32'd0);

        // Enter CLOCK_SET, snapshot 13:45:27
        press_mode();
        check("cs_mode", 32'(mode), 32'd1);
        check("cs_pos", 32'(pos), 32'd1);
        check("cs_snapshot", 32'(edit_now()), 32'(mk_time(1, 3, 4, 5, 2, 7)));
        check("cs_time_load", 32'(time_load), 32'd0);

        // Hour tens 1->2 (ones 3, no clamp) -> 0
        press_inc();
        check("ht_to_2", 32'(edit_now()), 32'(mk_time(2, 3, 4, 5, 2, 7)));
        press_inc();
        check("ht_wrap", 32'(edit_now()), 32'(mk_time(0, 3, 4, 5, 2, 7)));
        // Hour ones 3 -> 9
        press_next();
        check("pos_2", 32'(pos), 32'd2);
        repeat (6) press_inc();
        check("ho_to_9", 32'(edit_now()), 32'(mk_time(0, 9, 4, 5, 2, 7)));
        repeat (5) press_next();
        check("pos_back_1", 32'(pos), 32'd1);
        press_inc();
        check("ht_19", 32'(edit_now()), 32'(mk_time(1, 9, 4, 5, 2, 7)));
        press_inc();
        check("ht_clamp", 32'(edit_now()), 32'(mk_time(2, 3, 4, 5, 2, 7)));
        press_next();
        press_inc();
        check("ho_wrap_at_20", 32'(edit_now()), 32'(mk_time(2, 0, 4, 5, 2, 7)));

        // pos 6 -> 1, then leave CLOCK_SET with one-cycle load
        repeat (4) press_next();
        check("pos_6", 32'(pos), 32'd6);
        press_next();
        check("pos_wrap_1", 32'(pos), 32'd1);
        tl_base = tl_count;
        press_mode();
        check("load_high", 32'(time_load), 32'd1);
        check("load_edit", 32'(edit_now()), 32'(mk_time(2, 0, 4, 5, 2, 7)));
        check("as_mode", 32'(mode), 32'd2);
        check("as_pos", 32'(pos), 32'd1);
        @(negedge clk);
        check("load_low", 32'(time_load), 32'd0);
        check("load_once", 32'(tl_count - tl_base), 32'd1);

        // ALARM_SET: min ones x10 wraps without carry
        repeat (3) press_next();
        check("as_pos_4", 32'(pos), 32'd4);
        repeat (9) press_inc();
        check("alarm_0009", 32'(alarm_now()), 32'(mk_alarm(0, 0, 0, 9)));
        press_inc();
        check("alarm_wrap", 32'(alarm_now()), 32'(mk_alarm(0, 0, 0, 0)));
        press_next();
        check("as_pos_wrap", 32'(pos), 32'd1);
        press_inc();
        check("alarm_ht", 32'(alarm_now()), 32'(mk_alarm(1, 0, 0, 0)));
        check("edit_hold_as", 32'(edit_now()), 32'(mk_time(2, 0, 4, 5, 2, 7)));
        // btn_mode beats btn_inc
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("prio_mode", 32'(mode), 32'd0);
        check("prio_pos", 32'(pos), 32'd0);
        check("prio_alarm", 32'(alarm_now()), 32'(mk_alarm(1, 0, 0, 0)));
        check("prio_alarm_en", 32'(alarm_en), 32'd0);

        // Timeout after 3 idle ticks, no load
        set_cur(0, 8, 3, 0, 5, 9);
        tl_base = tl_count;
        press_mode();
        check("to_enter", 32'(mode), 32'd1);
        tick();
        tick();
        check("to_tick2", 32'(mode), 32'd1);
        tick();
        check("to_expire_mode", 32'(mode), 32'd0);
        check("to_expire_pos", 32'(pos), 32'd0);
        check("to_no_load", 32'(tl_count - tl_base), 32'd0);
        check("to_edit_kept", 32'(edit_now()), 32'(mk_time(0, 8, 3, 0, 5, 9)));

        // Button between ticks restarts the count; button beats a same-cycle tick
        press_mode();
        tick();
        tick();
        press_next();
        tick();
        check("to_restart_mode", 32'(mode), 32'd1);
        check("to_restart_pos", 32'(pos), 32'd2);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("to_cancel_mode", 32'(mode), 32'd1);
        check("to_cancel_pos", 32'(pos), 32'd3);
        tick();
        tick();
        check("to_cancel_tick2", 32'(mode), 32'd1);
        tick();
        check("to_second_expire", 32'(mode), 32'd0);
        check("to_second_no_load", 32'(tl_count - tl_base), 32'd0);

        // NORMAL: btn_inc toggles alarm_en; ticks do nothing
        press_inc();
        check("alarm_en_on", 32'(alarm_en), 32'd1);
        tick();
        check("normal_tick", 32'(mode), 32'd0);
        press_inc();
        check("alarm_en_off", 32'(alarm_en), 32'd0);

        // Reset mid CLOCK_SET
        set_cur(1, 1, 2, 2, 3, 3);
        tl_base = tl_count;
        press_mode();
        press_inc();
        check("pre_rst_edit", 32'(edit_now()), 32'(mk_time(2, 1, 2, 2, 3, 3)));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_mode", 32'(mode), 32'd0);
        check("mid_rst_pos", 32'(pos), 32'd0);
        check("mid_rst_edit", 32'(edit_now()), 32'd0);
        check("mid_rst_alarm", 32'(alarm_now()), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_no_load", 32'(tl_count - tl_base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
